// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   - opcode constants for every supported format
//   - NOP_INSTR: word substituted when the field tuple cannot be encoded
//   - fmt_e: format class selected by opcode
//   - op_fmt(): opcode -> format class lookup
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                     f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer and range checker.
//   opcode/rd/rs1/rs2/funct3/funct7/imm : field tuple to encode
//   instr : encoded word, or NOP_INSTR when err is set
//   err   : tuple cannot be represented (bad opcode or immediate)
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e fmt;
  logic is_shift;
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  // An immediate fits N signed bits when every bit above bit N-1 copies it.
  assign sext12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign sext13_ok = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign sext21_ok = (imm[31:20] == '0) || (imm[31:20] == '1);

  assign fmt      = op_fmt(opcode);
  assign is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          err   = !sext12_ok || (imm[11:5] != '0);
        end else begin
          instr = {imm[11:0], rs1, funct3, rd, opcode};
          err   = !sext12_ok;
        end
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !sext12_ok;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = imm[0] || !sext13_ok;
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != '0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = imm[0] || !sext21_ok;
      end
      default: err = 1'b1;
    endcase
    if (err) begin
      instr = NOP_INSTR;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I program encoder.
//   start/len           : begin a program of len words (accepted in IDLE only)
//   in_valid/in_ready   : field-tuple input handshake
//   in_*                : fields to encode
//   out_valid/out_ready : encoded-word output handshake
//   out_instr/out_addr  : encoded word and its target address
//   out_err             : word is a substituted NOP
//   done                : one-cycle pulse when a program completes
//   err_cnt             : saturating count of errored words in the program
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        done,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [31:0] ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        out_err_q, out_err_d;
  logic        done_q, done_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        out_hs;

  instr_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm32),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_cnt_d = '0;
          ptr_d     = BASE_ADDR;
          if (len != '0) begin
            state_d  = S_RUN;
            remain_d = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new acceptance overwrites the output register even while the old
    // word is handing off, so back-to-back words flow without a bubble.
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = pack_instr;
      out_addr_d  = ptr_q;
      out_err_d   = pack_err;
      ptr_d       = ptr_q + 32'd4;
      if (pack_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remain_q    <= '0;
      ptr_q       <= BASE_ADDR;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      out_err_q   <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // The completing handshake raises done in the same cycle; the registered
  // term covers the zero-length program.
  assign done      = done_q || ((state_q == S_DRAIN) && out_hs);
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        done;
  logic [7:0]  err_cnt;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm32  (in_imm32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .done      (done),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  int unsigned exp_errs = 0;
  int unsigned cur_len  = 0;
  int unsigned cur_idx  = 0;
  logic [31:0] exp_addr = BASE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshake is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_addr", out_addr, e.addr);
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
        check("done_on_hs", {31'd0, done}, {31'd0, e.last});
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic start_prog(input int unsigned n);
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[15:0];
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = BASE;
    exp_errs = 0;
    cur_len  = n;
    cur_idx  = 0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    logic ok;
    ok = 1'b0;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm32 = imm;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{instr: ei, addr: exp_addr, err: ee, last: (cur_idx == cur_len - 1)});
      exp_addr = exp_addr + 32'd4;
      cur_idx++;
      if (ee && exp_errs < 255) exp_errs++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_prog();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(negedge clk);
    exp_done++;
    check("err_cnt", {24'd0, err_cnt}, exp_errs);
    check("done_cnt", done_cnt, exp_done);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm32 = '0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single addi
    start_prog(1);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    finish_prog();

    // mixed formats, with a start pulse mid-run that must be ignored
    start_prog(9);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,          32'h0020_8463, 1'b0);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12,         32'h0020_A623, 1'b0);
    @(posedge clk); #1 start = 1'b1; len = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          32'h0020_81B3, 1'b0);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h0080_00EF, 1'b0);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3,          32'h0030_9093, 1'b0);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3,         32'h4030_D093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'hFFF0_0093, 1'b0);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h0000_0013, 1'b1);
    finish_prog();

    // lone out-of-range addi
    start_prog(1);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
    finish_prog();

    // error classes
    start_prog(7);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,         32'h0000_0013, 1'b1);
    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,      32'h0000_0013, 1'b1);
    send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 1'b1);
    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
    send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32,        32'h0000_0013, 1'b1);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048,      32'h0000_0013, 1'b1);
    finish_prog();

    // zero-length program: done one cycle after start, no output
    @(posedge clk); #1 start = 1'b1; len = 16'd0;
    @(posedge clk); #1 start = 1'b0;
    check("len0_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("len0_done_drop", {31'd0, done}, 32'd0);
    exp_done++;
    check("len0_done_cnt", done_cnt, exp_done);

    // output stall: out_* stable, in_ready low, then no-bubble handoff
    out_ready = 1'b0;
    start_prog(2);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    fork
      send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_instr", out_instr, 32'h0010_0093);
          check("stall_addr", out_addr, BASE);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    finish_prog();

    // error counter saturation
    start_prog(260);
    for (int i = 0; i < 260; i++)
      send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    finish_prog();

    // reset during RUN with a word pending
    out_ready = 1'b0;
    start_prog(3);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
    @(negedge clk);
    check("pre_rst_err_cnt", {24'd0, err_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_out_addr", out_addr, BASE);
    check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("rst_no_done", done_cnt, exp_done);
    start_prog(1);
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    finish_prog();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
